// File: rtl/fetch_if.sv
// Bundles the core-side and memory-side signals of the instruction fetch controller.
interface fetch_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32
);
    logic              start;
    logic              stall;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic [PC_W-1:0]   mem_pc;
    logic [INST_W-1:0] mem_inst;
    logic [INST_W-1:0] inst;
    logic              inst_valid;
    logic [PC_W-1:0]   fetch_pc;
    logic              busy;
    logic              halted;
    logic              err_oob;
    logic [31:0]       fetch_count;

    modport master (
        output start, stall, redirect, redirect_pc, mem_inst,
        input  mem_pc, inst, inst_valid, fetch_pc, busy, halted, err_oob, fetch_count
    );

    modport slave (
        input  start, stall, redirect, redirect_pc, mem_inst,
        output mem_pc, inst, inst_valid, fetch_pc, busy, halted, err_oob, fetch_count
    );
endinterface

// File: rtl/fetch_controller.sv
// Program counter and read sequencer for a 1-cycle-latency instruction memory.
// Optional HALT_ON_NOP_EN: an accepted all-zero instruction halts fetching.
module fetch_controller #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 128
) (
    input  logic   clk,
    input  logic   rst_n,
    fetch_if.slave fif
);
    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

    localparam logic [PC_W-1:0] LAST_PC = PC_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              issued_q, issued_d;
    logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic              err_oob_q, err_oob_d;
    logic [31:0]       fetch_count_q, fetch_count_d;
    logic              inst_valid;
    logic              accept;
    logic              halt_nop;

    assign inst_valid = issued_q & (state_q == FETCH);
    assign accept     = inst_valid & ~fif.stall;

`ifdef HALT_ON_NOP_EN
    assign halt_nop = accept & (fif.mem_inst == '0) & ~fif.redirect;
`else
    assign halt_nop = 1'b0;
`endif

    // A stalled consumer re-reads the held address so the registered memory output stays put.
    assign fif.mem_pc      = (fif.stall & issued_q & ~fif.redirect) ? fetch_pc_q : pc_q;
    assign fif.inst        = fif.mem_inst;
    assign fif.inst_valid  = inst_valid;
    assign fif.fetch_pc    = fetch_pc_q;
    assign fif.busy        = (state_q == FETCH);
    assign fif.halted      = (state_q == HALT);
    assign fif.err_oob     = err_oob_q;
    assign fif.fetch_count = fetch_count_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        issued_d      = issued_q;
        fetch_pc_d    = fetch_pc_q;
        err_oob_d     = err_oob_q;
        fetch_count_d = fetch_count_q;
        case (state_q)
            IDLE, HALT: begin
                if (fif.start) begin
                    state_d       = FETCH;
                    pc_d          = '0;
                    issued_d      = 1'b0;
                    fetch_count_d = '0;
                    err_oob_d     = 1'b0;
                end
            end
            FETCH: begin
                if (accept) begin
                    fetch_count_d = fetch_count_q + 32'd1;
                end
                if (fif.redirect) begin
                    pc_d     = fif.redirect_pc;
                    issued_d = 1'b0;
                end else if (halt_nop) begin
                    state_d  = HALT;
                    issued_d = 1'b0;
                end else if (!fif.stall) begin
                    if (pc_q > LAST_PC) begin
                        state_d   = HALT;
                        err_oob_d = 1'b1;
                        issued_d  = 1'b0;
                    end else begin
                        fetch_pc_d = pc_q;
                        pc_d       = pc_q + 1'b1;
                        issued_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            issued_q      <= 1'b0;
            fetch_pc_q    <= '0;
            err_oob_q     <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            issued_q      <= issued_d;
            fetch_pc_q    <= fetch_pc_d;
            err_oob_q     <= err_oob_d;
            fetch_count_q <= fetch_count_d;
        end
    end
endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a behavioural 1-cycle-latency instruction memory.
module tb_fetch_controller;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [31:0] mem [0:127];

    fetch_if #(.PC_W(32), .INST_W(32)) fif ();

    fetch_controller #(.PC_W(32), .INST_W(32), .DEPTH(128)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fif   (fif.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fif.mem_pc < 32'd128) fif.mem_inst <= mem[fif.mem_pc[6:0]];
        else                      fif.mem_inst <= 32'hDEAD_BEEF;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        fif.start = 1'b1;
        @(negedge clk);
        fif.start = 1'b0;
    endtask

    task automatic wait_pc(input logic [31:0] target);
        bit found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (fif.inst_valid && fif.fetch_pc == target) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) check_eq("wait_timeout", 64'(fif.fetch_pc), 64'(target));
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h0;
        fif.mem_inst    = '0;
        rst_n           = 1'b0;
        fif.start       = 1'b0;
        fif.stall       = 1'b0;
        fif.redirect    = 1'b0;
        fif.redirect_pc = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_valid", 64'(fif.inst_valid), 64'd0);
        check_eq("rst_busy", 64'(fif.busy), 64'd0);
        check_eq("rst_halted", 64'(fif.halted), 64'd0);
        check_eq("rst_fetch_pc", 64'(fif.fetch_pc), 64'd0);
        check_eq("rst_err", 64'(fif.err_oob), 64'd0);
        check_eq("rst_count", 64'(fif.fetch_count), 64'd0);
        rst_n = 1'b1;

        fif.redirect = 1'b1; fif.redirect_pc = 32'd50;
        @(negedge clk);
        fif.redirect = 1'b0;
        check_eq("idle_redir_busy", 64'(fif.busy), 64'd0);
        check_eq("idle_redir_mem_pc", 64'(fif.mem_pc), 64'd0);

        pulse_start();
        check_eq("start_busy", 64'(fif.busy), 64'd1);
        check_eq("start_valid", 64'(fif.inst_valid), 64'd0);
        @(negedge clk);
        check_eq("first_valid", 64'(fif.inst_valid), 64'd1);
        check_eq("first_pc", 64'(fif.fetch_pc), 64'd0);
        check_eq("first_inst", 64'(fif.inst), 64'h11);
        check_eq("first_count", 64'(fif.fetch_count), 64'd0);
        @(negedge clk);
        check_eq("pc1", 64'(fif.fetch_pc), 64'd1);
        check_eq("inst1", 64'(fif.inst), 64'h22);
        @(negedge clk);
        check_eq("pc2", 64'(fif.fetch_pc), 64'd2);
        check_eq("inst2", 64'(fif.inst), 64'h33);
        check_eq("count2", 64'(fif.fetch_count), 64'd2);

        fif.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("stall_pc", 64'(fif.fetch_pc), 64'd2);
            check_eq("stall_inst", 64'(fif.inst), 64'h33);
            check_eq("stall_valid", 64'(fif.inst_valid), 64'd1);
            check_eq("stall_count", 64'(fif.fetch_count), 64'd2);
        end
        fif.stall = 1'b0;
        @(negedge clk);
        check_eq("resume_pc", 64'(fif.fetch_pc), 64'd3);
        check_eq("resume_inst", 64'(fif.inst), 64'h0);
        check_eq("resume_count", 64'(fif.fetch_count), 64'd3);
        @(negedge clk);
`ifdef HALT_ON_NOP_EN
        check_eq("nop_halted", 64'(fif.halted), 64'd1);
        check_eq("nop_valid", 64'(fif.inst_valid), 64'd0);
        check_eq("nop_count", 64'(fif.fetch_count), 64'd4);
        pulse_start();
        check_eq("restart_busy", 64'(fif.busy), 64'd1);
        check_eq("restart_count", 64'(fif.fetch_count), 64'd0);
`else
        check_eq("nop_halted", 64'(fif.halted), 64'd0);
        check_eq("nop_pc4", 64'(fif.fetch_pc), 64'd4);
        check_eq("nop_count", 64'(fif.fetch_count), 64'd4);
`endif

        wait_pc(32'd5);
        check_eq("pc5_count", 64'(fif.fetch_count), 64'd5);
        fif.redirect = 1'b1; fif.redirect_pc = 32'd10; fif.stall = 1'b1;
        @(negedge clk);
        fif.redirect = 1'b0; fif.stall = 1'b0;
        check_eq("bubble_valid", 64'(fif.inst_valid), 64'd0);
        check_eq("bubble_count", 64'(fif.fetch_count), 64'd5);
        check_eq("bubble_mem_pc", 64'(fif.mem_pc), 64'd10);
        @(negedge clk);
        check_eq("target_valid", 64'(fif.inst_valid), 64'd1);
        check_eq("target_pc", 64'(fif.fetch_pc), 64'd10);
        check_eq("target_inst", 64'(fif.inst), 64'h1000_000a);
        check_eq("target_count", 64'(fif.fetch_count), 64'd5);
        @(negedge clk);
        check_eq("pc11", 64'(fif.fetch_pc), 64'd11);
        check_eq("pc11_count", 64'(fif.fetch_count), 64'd6);

        fif.redirect = 1'b1; fif.redirect_pc = 32'd120;
        @(negedge clk);
        fif.redirect = 1'b0;
        check_eq("redir_acc_valid", 64'(fif.inst_valid), 64'd0);
        check_eq("redir_acc_count", 64'(fif.fetch_count), 64'd7);
        @(negedge clk);
        check_eq("pc120", 64'(fif.fetch_pc), 64'd120);
        wait_pc(32'd127);
        check_eq("pc127_count", 64'(fif.fetch_count), 64'd14);
        check_eq("pc127_err", 64'(fif.err_oob), 64'd0);
        check_eq("pc127_halted", 64'(fif.halted), 64'd0);
        @(negedge clk);
        check_eq("oob_halted", 64'(fif.halted), 64'd1);
        check_eq("oob_err", 64'(fif.err_oob), 64'd1);
        check_eq("oob_valid", 64'(fif.inst_valid), 64'd0);
        check_eq("oob_busy", 64'(fif.busy), 64'd0);
        check_eq("oob_count", 64'(fif.fetch_count), 64'd15);

`ifndef HALT_ON_NOP_EN
        pulse_start();
        check_eq("full_start_err", 64'(fif.err_oob), 64'd0);
        check_eq("full_start_count", 64'(fif.fetch_count), 64'd0);
        wait_pc(32'd127);
        @(negedge clk);
        check_eq("full_count", 64'(fif.fetch_count), 64'd128);
        check_eq("full_err", 64'(fif.err_oob), 64'd1);
        check_eq("full_halted", 64'(fif.halted), 64'd1);
`endif

        pulse_start();
        wait_pc(32'd7);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", 64'(fif.inst_valid), 64'd0);
        check_eq("midrst_pc", 64'(fif.fetch_pc), 64'd0);
        check_eq("midrst_busy", 64'(fif.busy), 64'd0);
        check_eq("midrst_count", 64'(fif.fetch_count), 64'd0);
        check_eq("midrst_mem_pc", 64'(fif.mem_pc), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        @(negedge clk);
        check_eq("refetch_valid", 64'(fif.inst_valid), 64'd1);
        check_eq("refetch_pc", 64'(fif.fetch_pc), 64'd0);
        check_eq("refetch_inst", 64'(fif.inst), 64'h11);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
